// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, arbiter states and burst lengths
package sdram_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    // Shared with the as4c4m32s_controller instantiation so both sides agree.
    localparam int SDRAM_READ_BURST  = 8;
    localparam int SDRAM_WRITE_BURST = 1;

    // State encoding doubles as the controller command.
    typedef enum logic [1:0] {
        ARB_IDLE  = CMD_IDLE,
        ARB_WRITE = CMD_WRITE,
        ARB_READ  = CMD_READ
    } arb_state_t;

    function automatic int count_width(input int max_len);
        return (max_len <= 1) ? 1 : $clog2(max_len);
    endfunction

endpackage

// File: rtl/sdram_arbiter_burst_counter.sv
// rtl/sdram_arbiter_burst_counter.sv - loadable down-counter of remaining burst beats
module burst_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - whole-burst read/write arbiter for the SDRAM controller; SDRAM_ARB_STARVATION_GUARD_EN enables the write starvation guard
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH         = 22,
    parameter int DATA_WIDTH         = 32,
    parameter int READ_BURST_LENGTH  = SDRAM_READ_BURST,
    parameter int WRITE_BURST_LENGTH = SDRAM_WRITE_BURST,
    parameter int MAX_READ_STREAK    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_grant,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_pop,
    output logic                  wr_done,
    output logic [1:0]            command,
    output logic [ADDR_WIDTH-1:0] data_address,
    output logic [DATA_WIDTH-1:0] data_write,
    input  logic [DATA_WIDTH-1:0] data_read,
    input  logic                  data_read_valid,
    input  logic                  data_write_done,
    output logic                  busy
);

    localparam int MAX_BURST = (READ_BURST_LENGTH > WRITE_BURST_LENGTH) ?
                               READ_BURST_LENGTH : WRITE_BURST_LENGTH;
    localparam int CW = count_width(MAX_BURST);
    localparam logic [CW-1:0] READ_LOAD  = CW'(READ_BURST_LENGTH - 1);
    localparam logic [CW-1:0] WRITE_LOAD = CW'(WRITE_BURST_LENGTH - 1);

    if (READ_BURST_LENGTH < 1 || WRITE_BURST_LENGTH < 1 || MAX_READ_STREAK < 1) begin : g_param_check
        $error("sdram_arbiter: burst lengths and MAX_READ_STREAK must be at least 1");
    end

    arb_state_t state;
    logic       beat_last;
    logic       take_read;
    logic       take_write;
    logic       read_beat;
    logic       write_beat;
    logic       write_first;

`ifdef SDRAM_ARB_STARVATION_GUARD_EN
    localparam int SW = $clog2(MAX_READ_STREAK + 1);
    logic [SW-1:0] streak;

    assign write_first = wr_req && (streak >= SW'(MAX_READ_STREAK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (take_write) begin
            streak <= '0;
        end else if (take_read && wr_req) begin
            streak <= streak + 1'b1;
        end
    end
`else
    assign write_first = 1'b0;
`endif

    // Grants are gated by reset so no strobe escapes while the controller is held.
    assign take_read  = (state == ARB_IDLE) && !reset && rd_req && !write_first;
    assign take_write = (state == ARB_IDLE) && !reset && wr_req && (!rd_req || write_first);
    assign read_beat  = (state == ARB_READ) && data_read_valid;
    assign write_beat = (state == ARB_WRITE) && data_write_done;

    burst_counter #(
        .WIDTH(CW)
    ) u_beats (
        .clk        (clk),
        .rst        (reset),
        .load       (take_read || take_write),
        .load_value (take_read ? READ_LOAD : WRITE_LOAD),
        .dec        ((read_beat || write_beat) && !beat_last),
        .last       (beat_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ARB_IDLE;
            data_address <= '0;
            data_write   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (take_read) begin
                        state        <= ARB_READ;
                        data_address <= rd_addr;
                    end else if (take_write) begin
                        state        <= ARB_WRITE;
                        data_address <= wr_addr;
                        data_write   <= wr_data;
                    end
                end
                ARB_READ: begin
                    if (data_read_valid) begin
                        data_address <= data_address + 1'b1;
                        if (beat_last) state <= ARB_IDLE;
                    end
                end
                ARB_WRITE: begin
                    if (data_write_done) begin
                        data_address <= data_address + 1'b1;
                        if (beat_last) state <= ARB_IDLE;
                        else           data_write <= wr_data;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign command  = state;
    assign busy     = (state != ARB_IDLE);
    assign rd_grant = take_read;
    assign rd_valid = read_beat;
    assign rd_last  = read_beat && beat_last;
    assign rd_data  = (state == ARB_READ) ? data_read : '0;
    // The FWFT head is consumed in the same cycle it is captured.
    assign wr_pop   = take_write || (write_beat && !beat_last);
    assign wr_done  = write_beat && beat_last;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Sits between the as4c4m32s_controller command interface and two requesters:
  - Display read path: fills the LCD pixel FIFO with read bursts.
  - Pixel compute path: writes rendered words from a first-word-fall-through (FWFT) source.
- Grants whole bursts and holds the controller command for the full burst.
- Counts beats, auto-increments the address, and routes data and strobes back to the granted requester.
- Replaces the ad-hoc init/readback sequencing in the top level.

Parameters:
- ADDR_WIDTH, 22: controller word address width.
- DATA_WIDTH, 32: data word width.
- READ_BURST_LENGTH, 8: beats per read grant; must match the controller parameter.
- WRITE_BURST_LENGTH, 1: beats per write grant; must match the controller WRITE_BURST.
- MAX_READ_STREAK, 4: consecutive read grants allowed while a write is pending (optional feature only).

Ports:
- clk  in  1  controller clock (MEM_CLK domain).
- reset  in  1  asynchronous, active-high.
- rd_req  in  1  read burst wanted; level, sampled in IDLE.
- rd_addr  in  ADDR_WIDTH  first word address of the read burst.
- rd_grant  out  1  one-cycle pulse: read burst accepted, rd_addr captured.
- rd_data  out  DATA_WIDTH  data_read passthrough.
- rd_valid  out  1  beat valid; = data_read_valid & (state==READ).
- rd_last  out  1  rd_valid on the final beat.
- wr_req  in  1  write burst wanted; FWFT source holds at least WRITE_BURST_LENGTH words.
- wr_addr  in  ADDR_WIDTH  first word address of the write burst.
- wr_data  in  DATA_WIDTH  current FWFT head word.
- wr_pop  out  1  one-cycle pulse: wr_data captured, source advances its head.
- wr_done  out  1  one-cycle pulse on the final data_write_done of a burst.
- command  out  2  to controller: 0 IDLE, 1 WRITE, 2 READ.
- data_address  out  ADDR_WIDTH  to controller.
- data_write  out  DATA_WIDTH  to controller.
- data_read  in  DATA_WIDTH  from controller.
- data_read_valid  in  1  from controller.
- data_write_done  in  1  from controller.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE; command 0, data_address 0, data_write 0, beat counter 0, streak counter 0. rd_grant, wr_pop and wr_done are 0. Combinational outputs evaluate to 0 in IDLE.
- States: IDLE, READ, WRITE. command is registered and equals the state encoding.
- IDLE arbitration is fixed read priority:
  - If rd_req=1: next state READ; data_address<=rd_addr; beat counter<=READ_BURST_LENGTH-1; rd_grant=1 for one cycle.
  - Else if wr_req=1: next state WRITE; data_address<=wr_addr; data_write<=wr_data; beat counter<=WRITE_BURST_LENGTH-1; wr_pop=1 for one cycle.
  - Else: remain in IDLE.
- READ: on each cycle with data_read_valid=1, data_address<=data_address+1 (mod 2^ADDR_WIDTH).
  - If the counter is 0: rd_last=1 and the next state is IDLE.
  - Otherwise: decrement the counter.
- WRITE: on each data_write_done=1, data_address<=data_address+1.
  - If the counter is 0: wr_done=1 and the next state is IDLE.
  - Otherwise: decrement the counter; data_write<=wr_data; wr_pop=1.
  - Total pops per burst = WRITE_BURST_LENGTH.
- After every burst, command stays IDLE for at least one cycle before the next grant.
- Requests are not re-sampled mid-burst. Deasserting rd_req or wr_req during a burst has no effect.
- Strobes outside their state are ignored: data_read_valid outside READ and data_write_done outside WRITE produce no outputs and no counter change.
- Address wrap-around at 2^ADDR_WIDTH-1 -> 0 is permitted inside a burst. Frame-size wrap is the requester's job.
- Reset mid-burst: all state returns to the reset values immediately. The controller is reset by the same reset; the partial burst is lost with no rd_last or wr_done.
- Latency: grant at IDLE edge N puts the command on the controller at N+1.

Optional Feature:
- SDRAM_ARB_STARVATION_GUARD_EN defined:
  - A streak counter increments on each read grant made while wr_req=1 and clears on each write grant.
  - When the counter reaches MAX_READ_STREAK and wr_req=1, IDLE grants the write even if rd_req=1.
- Not defined: pure read priority, and the streak logic is absent.

Decomposition:
- Shared package sdram_pkg:
  - Command encodings CMD_IDLE, CMD_WRITE, CMD_READ.
  - Arbiter state enum.
  - Burst-length constants also used by the controller instantiation.
- Sub-module burst_counter: load / decrement / last flag, instanced once and reused for both burst types.

Test Plan:
- Read only: rd_req=1, rd_addr=0x100, 8 valids -> one rd_grant; command=2 for the burst; addresses 0x100..0x107; rd_last on beat 8; command=0 for at least 1 cycle.
- Write only: wr_req=1, wr_addr=0x3FFFFF, WRITE_BURST_LENGTH=2, heads A,B -> pops at grant and after done 1; data_write A then B; address wraps to 0; wr_done on done 2.
- Simultaneous rd_req and wr_req in IDLE -> read granted first; write granted on the first IDLE cycle after rd_last.
- Starvation guard: macro on, MAX_READ_STREAK=4, rd_req and wr_req held at 1 -> grant order R,R,R,R,W,R.
- Stray strobes: data_read_valid pulses in IDLE and WRITE -> rd_valid stays 0, address unchanged.
- Reset asserted at beat 3 of a read -> command=0 and busy=0 immediately; no rd_last; next rd_req is granted cleanly.
